// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer, a host write strobe and a read fetch port.
// Define I2C_TGT_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter after the synchroniser.
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADDR   = 7'h40,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] PTR_WRAP   = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       wr_stb_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       rd_stb_o,
    output logic [7:0] rd_addr_o,
    input  logic [7:0] rd_data_i,
    output logic       busy_o,
    output logic       nack_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
    } state_t;

    // Bit 1 carries SCL, bit 0 carries SDA; the idle bus level is high.
    logic [1:0] raw, sync1_q, sync2_q, cond, prev_q;
    assign raw = {scl_i, sda_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= cond;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic [3:0] cnt_q;
        logic       filt_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else if (sync2_q[gi] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                filt_q <= sync2_q[gi];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
        assign cond[gi] = filt_q;
    end
`else
    assign cond = sync2_q;
`endif

    logic scl_rise, scl_fall, start_evt, stop_evt, sda_c;
    assign sda_c     = cond[0];
    assign scl_rise  = cond[1] & ~prev_q[1];
    assign scl_fall  = ~cond[1] & prev_q[1];
    assign start_evt = cond[1] & prev_q[1] & prev_q[0] & ~cond[0];
    assign stop_evt  = cond[1] & prev_q[1] & ~prev_q[0] & cond[0];

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d, ptr_q, ptr_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic       oe_q, oe_d, wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
    logic       nack_q, nack_d, mack_q, mack_d, load_rd;

    logic       byte_done, addr_match;
    logic [7:0] ptr_inc;
    assign byte_done  = (cnt_q == 4'd8);
    assign addr_match = (rx_q[7:1] == TGT_ADDR);
    assign ptr_inc    = (ptr_q == PTR_WRAP) ? 8'h00 : ptr_q + 8'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            oe_q      <= 1'b0;
            wr_stb_q  <= 1'b0;
            rd_stb_q  <= 1'b0;
            nack_q    <= 1'b0;
            mack_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            oe_q      <= oe_d;
            wr_stb_q  <= wr_stb_d;
            rd_stb_q  <= rd_stb_d;
            nack_q    <= nack_d;
            mack_q    <= mack_d;
        end
    end

    // Bus conditions override everything; otherwise states advance on SCL falling edges.
    always_comb begin
        state_d = state_q;
        if (start_evt) begin
            state_d = S_ADDR;
        end else if (stop_evt) begin
            state_d = S_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR:      if (byte_done) state_d = addr_match ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:  state_d = rx_q[0] ? S_RDATA : S_PTR;
                S_PTR:       if (byte_done) state_d = S_PTR_ACK;
                S_PTR_ACK:   state_d = S_WDATA;
                S_WDATA:     if (byte_done) state_d = S_WDATA_ACK;
                S_WDATA_ACK: state_d = S_WDATA;
                S_RDATA:     if (byte_done) state_d = S_RDATA_ACK;
                S_RDATA_ACK: state_d = mack_q ? S_IDLE : S_RDATA;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        oe_d      = oe_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        nack_d    = 1'b0;
        mack_d    = mack_q;
        load_rd   = 1'b0;
        if (start_evt || stop_evt) begin
            cnt_d = '0;
            oe_d  = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    rx_d  = {rx_q[6:0], sda_c};
                    cnt_d = cnt_q + 4'd1;
                end
                S_RDATA:     cnt_d  = cnt_q + 4'd1;
                S_RDATA_ACK: mack_d = sda_c;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                S_ADDR: if (byte_done) begin
                    cnt_d = '0;
                    if (addr_match) oe_d = 1'b1;
                    else            nack_d = 1'b1;
                end
                S_ADDR_ACK: begin
                    cnt_d = '0;
                    if (rx_q[0]) load_rd = 1'b1;
                    else         oe_d = 1'b0;
                end
                S_PTR: if (byte_done) begin
                    ptr_d = rx_q;
                    oe_d  = 1'b1;
                    cnt_d = '0;
                end
                S_WDATA: if (byte_done) begin
                    oe_d      = 1'b1;
                    wr_stb_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = rx_q;
                    ptr_d     = ptr_inc;
                    cnt_d     = '0;
                end
                S_PTR_ACK, S_WDATA_ACK: oe_d = 1'b0;
                S_RDATA: begin
                    if (byte_done) begin
                        oe_d  = 1'b0;
                        cnt_d = '0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                        oe_d = ~tx_q[6];
                    end
                end
                S_RDATA_ACK: begin
                    if (!mack_q) load_rd = 1'b1;
                    else         oe_d = 1'b0;
                end
                default: ;
            endcase
            // Fetch the byte at the pointer and present its MSB straight away.
            if (load_rd) begin
                tx_d     = rd_data_i;
                oe_d     = ~rd_data_i[7];
                rd_stb_d = 1'b1;
                ptr_d    = ptr_inc;
                cnt_d    = '0;
            end
        end
    end

    assign sda_oe_o  = oe_q;
    assign wr_stb_o  = wr_stb_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign rd_stb_o  = rd_stb_q;
    assign rd_addr_o = ptr_q;
    assign nack_o    = nack_q;
    assign busy_o    = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C controller plus scoreboards for write strobes and read bytes.
module tb_i2c_target_regs;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       scl_bus, sda_bus;
    logic       sda_oe_o, wr_stb_o, rd_stb_o, busy_o, nack_o;
    logic [7:0] wr_addr_o, wr_data_o, rd_addr_o, rd_data;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0, rd_cnt = 0, nack_cnt = 0, oe_cycles = 0, hi_viol = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t        wr_q[$];
    wr_t        wr_exp;
    logic [7:0] rd_q[$];
    logic [7:0] ptr_model;
    logic       oe_prev = 1'b0;
    logic       rst_prev = 1'b1;

    assign scl_bus = scl_drv;
    assign sda_bus = sda_drv & ~sda_oe_o;
    assign rd_data = rd_addr_o ^ 8'h5A;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl_bus),
        .sda_i     (sda_bus),
        .sda_oe_o  (sda_oe_o),
        .wr_stb_o  (wr_stb_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .rd_stb_o  (rd_stb_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data),
        .busy_o    (busy_o),
        .nack_o    (nack_o)
    );

    // Scoreboard monitor: each write strobe pops the oldest expected (addr, data).
    always @(negedge clk) begin
        if (wr_stb_o) begin
            wr_cnt++;
            tests++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got (%02h,%02h), required no strobe", wr_addr_o, wr_data_o);
            end else begin
                wr_exp = wr_q.pop_front();
                if ({wr_addr_o, wr_data_o} !== {wr_exp.a, wr_exp.d}) begin
                    fails++;
                    $display("FAIL wr_strobe: got (%02h,%02h), required (%02h,%02h)",
                             wr_addr_o, wr_data_o, wr_exp.a, wr_exp.d);
                end else begin
                    $display("[TB] write addr=%02h data=%02h", wr_addr_o, wr_data_o);
                end
            end
        end
        if (rd_stb_o) rd_cnt++;
        if (nack_o) nack_cnt++;
        if (sda_oe_o) oe_cycles++;
        if (!rst && !rst_prev && (sda_oe_o !== oe_prev) && scl_bus) hi_viol++;
        oe_prev  = sda_oe_o;
        rst_prev = rst;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        if (!scl_drv) begin
            sda_drv = 1'b1; wait_clk(Q);
            scl_drv = 1'b1; wait_clk(Q);
        end
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        sda_drv = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    wait_clk(Q);
        scl_drv = 1'b1; wait_clk(2 * Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic ack_slot(output logic ack);
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        ack = sda_bus;  wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_slot(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] data);
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            scl_drv = 1'b1; wait_clk(Q);
            data[i] = sda_bus; wait_clk(Q);
            scl_drv = 1'b0;
        end
        wait_clk(Q);
        send_bit(ack_bit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        tests++; if (sda_oe_o !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b, required 0", sda_oe_o); end
        tests++; if (wr_stb_o !== 1'b0) begin fails++; $display("FAIL rst_wr_stb: got %b, required 0", wr_stb_o); end
        tests++; if (rd_stb_o !== 1'b0) begin fails++; $display("FAIL rst_rd_stb: got %b, required 0", rd_stb_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
        tests++; if (nack_o !== 1'b0) begin fails++; $display("FAIL rst_nack: got %b, required 0", nack_o); end
        tests++; if (wr_addr_o !== 8'h00) begin fails++; $display("FAIL rst_wr_addr: got %02h, required 00", wr_addr_o); end
        tests++; if (wr_data_o !== 8'h00) begin fails++; $display("FAIL rst_wr_data: got %02h, required 00", wr_data_o); end
        tests++; if (rd_addr_o !== 8'h00) begin fails++; $display("FAIL rst_ptr: got %02h, required 00", rd_addr_o); end
        $display("[TB] reset checked");
    endtask

    task automatic test_write();
        logic [7:0] bytes [4];
        logic       ack;
        int         w0;
        bytes = '{8'h80, 8'h02, 8'hA5, 8'h3C};
        w0 = wr_cnt;
        bus_start();
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL write_busy: got %b, required 1", busy_o); end
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) wr_q.push_back('{8'(8'h02 + 8'(i - 2)), bytes[i]});
            write_byte(bytes[i], ack);
            tests++;
            if (ack !== 1'b0) begin fails++; $display("FAIL write_ack%0d: got %b, required 0", i, ack); end
        end
        bus_stop();
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL write_busy_stop: got %b, required 0", busy_o); end
        tests++; if (wr_cnt - w0 !== 2) begin fails++; $display("FAIL write_count: got %0d, required 2", wr_cnt - w0); end
        tests++; if (wr_q.size() !== 0) begin fails++; $display("FAIL write_pending: got %0d, required 0", wr_q.size()); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] data, exp;
        int         r0;
        r0 = rd_cnt;
        bus_start();
        write_byte(8'h80, ack);
        write_byte(8'h10, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL read_ptr_ack: got %b, required 0", ack); end
        ptr_model = 8'h10;
        bus_start();
        write_byte(8'h81, ack);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL read_addr_ack: got %b, required 0", ack); end
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back(ptr_model ^ 8'h5A);
            ptr_model = ptr_model + 8'd1;
            read_byte(i == 1, data);
            exp = rd_q.pop_front();
            tests++;
            if (data !== exp) begin fails++; $display("FAIL read_byte%0d: got %02h, required %02h", i, data, exp); end
            else $display("[TB] read data=%02h", data);
        end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL read_idle: got busy %b, required 0", busy_o); end
        bus_stop();
        tests++; if (rd_cnt - r0 !== 2) begin fails++; $display("FAIL read_stb_count: got %0d, required 2", rd_cnt - r0); end
        tests++; if (rd_addr_o !== ptr_model) begin fails++; $display("FAIL read_ptr: got %02h, required %02h", rd_addr_o, ptr_model); end
    endtask

    task automatic test_nack();
        logic ack;
        int   n0, o0, w0;
        n0 = nack_cnt; o0 = oe_cycles; w0 = wr_cnt;
        bus_start();
        write_byte(8'h82, ack);
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL nack_addr_ack: got %b, required 1", ack); end
        write_byte(8'h55, ack);
        tests++; if (ack !== 1'b1) begin fails++; $display("FAIL nack_silent: got %b, required 1", ack); end
        bus_stop();
        tests++; if (nack_cnt - n0 !== 1) begin fails++; $display("FAIL nack_pulse: got %0d, required 1", nack_cnt - n0); end
        tests++; if (oe_cycles - o0 !== 0) begin fails++; $display("FAIL nack_oe: got %0d cycles, required 0", oe_cycles - o0); end
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL nack_strobes: got %0d, required 0", wr_cnt - w0); end
        $display("[TB] nack transaction addr=41");
    endtask

    task automatic test_wrap();
        logic ack;
        bus_start();
        write_byte(8'h80, ack);
        write_byte(8'hFF, ack);
        wr_q.push_back('{8'hFF, 8'h11});
        write_byte(8'h11, ack);
        wr_q.push_back('{8'h00, 8'h22});
        write_byte(8'h22, ack);
        bus_stop();
        tests++; if (wr_q.size() !== 0) begin fails++; $display("FAIL wrap_pending: got %0d, required 0", wr_q.size()); end
        tests++; if (rd_addr_o !== 8'h01) begin fails++; $display("FAIL wrap_ptr: got %02h, required 01", rd_addr_o); end
    endtask

    task automatic test_stop_mid_byte();
        logic ack;
        int   w0;
        w0 = wr_cnt;
        bus_start();
        write_byte(8'h80, ack);
        write_byte(8'h30, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL stopmid_strobe: got %0d, required 0", wr_cnt - w0); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL stopmid_busy: got %b, required 0", busy_o); end
        tests++; if (rd_addr_o !== 8'h30) begin fails++; $display("FAIL stopmid_ptr: got %02h, required 30", rd_addr_o); end
        $display("[TB] stop after 4 data bits");
    endtask

    task automatic test_abort();
        logic ack;
        int   w0;
        w0 = wr_cnt;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 7);
        sda_drv = 1'b1; wait_clk(Q);
        scl_drv = 1'b1; wait_clk(Q);
        tests++; if (sda_oe_o !== 1'b1) begin fails++; $display("FAIL abort_ack_drive: got %b, required 1", sda_oe_o); end
        rst = 1'b1; wait_clk(1);
        rst = 1'b0;
        tests++; if (sda_oe_o !== 1'b0) begin fails++; $display("FAIL abort_oe: got %b, required 0", sda_oe_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b, required 0", busy_o); end
        wait_clk(Q);
        scl_drv = 1'b0; wait_clk(Q);
        bus_stop();
        bus_start();
        write_byte(8'h80, ack);
        write_byte(8'h60, ack);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        rst = 1'b1; wait_clk(1);
        rst = 1'b0;
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL abort2_busy: got %b, required 0", busy_o); end
        tests++; if (rd_addr_o !== 8'h00) begin fails++; $display("FAIL abort2_ptr: got %02h, required 00", rd_addr_o); end
        bus_stop();
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL abort_strobe: got %0d, required 0", wr_cnt - w0); end
        $display("[TB] reset abort mid-transaction");
    endtask

    task automatic test_glitch();
        localparam int K = 3;
        logic [7:0] b, e;
        logic       ack, exp_ack;
        b = 8'hA5;
`ifdef I2C_TGT_GLITCH_FILTER_EN
        e = b;
        exp_ack = 1'b0;
`else
        // The glitch adds a clock that samples bit K twice; the byte ends one bit early.
        for (int j = 0; j < 8; j++) e[7 - j] = b[7 - ((j <= K) ? j : j - 1)];
        exp_ack = 1'b1;
`endif
        bus_start();
        write_byte(8'h80, ack);
        write_byte(8'h50, ack);
        wr_q.push_back('{8'h50, e});
        for (int i = 0; i < 8; i++) begin
            sda_drv = b[7 - i]; wait_clk(Q);
            scl_drv = 1'b1;
            if (i == K) begin
                wait_clk(Q / 2);
                scl_drv = 1'b0; wait_clk(2);
                scl_drv = 1'b1; wait_clk(2 * Q - Q / 2 - 2);
            end else begin
                wait_clk(2 * Q);
            end
            scl_drv = 1'b0; wait_clk(Q);
        end
        ack_slot(ack);
        tests++; if (ack !== exp_ack) begin fails++; $display("FAIL glitch_ack: got %b, required %b", ack, exp_ack); end
        bus_stop();
        tests++; if (wr_q.size() !== 0) begin fails++; $display("FAIL glitch_pending: got %0d, required 0", wr_q.size()); end
    endtask

    task automatic test_bus_rules();
        tests++;
        if (hi_viol !== 0) begin fails++; $display("FAIL oe_scl_high: got %0d changes, required 0", hi_viol); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_wrap();
        test_stop_mid_byte();
        test_abort();
        test_glitch();
        test_bus_rules();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
